// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

  localparam int unsigned PISO_WIDTH_DEF = 8;
  localparam int unsigned PISO_CNT_W_DEF = $clog2(PISO_WIDTH_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  function automatic int unsigned piso_cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial output strobes of the serializer.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEF
);

  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             ser_o;
  logic             frame_o;
  logic             last_o;
  logic             busy_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, ser_o, frame_o, last_o, busy_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, ser_o, frame_o, last_o, busy_o
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit position counter: clears on load, otherwise increments; flags the final bit.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               load_i,
  input  logic                               inc_i,
  output logic [piso_cnt_width(WIDTH)-1:0]   cnt_o,
  output logic                               term_o
);

  localparam int unsigned CNT_W = piso_cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// consecutive frames stream without an idle cycle between them.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  piso_serializer_if.slave   bus
);

  localparam int unsigned CNT_W = piso_cnt_width(WIDTH);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, hold_q, shift_nx;
  logic             hold_full_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;
  logic             xfer;
  logic             ld_data, ld_hold, hold_set, hold_clr;
  logic             cnt_load, cnt_inc;

  assign xfer = bus.valid_i && bus.ready_o;

  // Counter is parked at zero while idle and on every frame boundary, so a new
  // frame always starts at bit 0 whichever path loaded shift_q.
  assign cnt_load = (state_q == ST_IDLE) || cnt_term;
  assign cnt_inc  = (state_q == ST_SHIFT);

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .term_o (cnt_term)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_data  = 1'b0;
    ld_hold  = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          ld_data = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!cnt_term) begin
          hold_set = xfer;
        end else if (hold_full_q) begin
          ld_hold  = 1'b1;
          hold_clr = 1'b1;
        end else if (xfer) begin
          ld_data = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ser_o   = 1'b0;
    bus.frame_o = 1'b0;
    bus.last_o  = 1'b0;
    bus.busy_o  = 1'b0;
    bus.ready_o = !hold_full_q && !rst_i;
    if (state_q == ST_SHIFT) begin
      bus.ser_o   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
      bus.frame_o = (cnt == '0);
      bus.last_o  = cnt_term;
      bus.busy_o  = 1'b1;
    end
  end

  assign shift_nx = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (ld_data) begin
        shift_q <= bus.data_i;
      end else if (ld_hold) begin
        shift_q <= hold_q;
      end else if (state_q == ST_SHIFT) begin
        shift_q <= shift_nx;
      end

      if (hold_set) begin
        hold_q      <= bus.data_i;
        hold_full_q <= 1'b1;
      end else if (hold_clr) begin
        hold_full_q <= 1'b0;
      end
    end
  end

endmodule
